flit_serializer: RTL and testbench

- Downstream neighbour of the fabric-port packetizer.
- Accepts one wide word of 4 packed flits (flit 0 in the MSBs) per handshake and emits the valid flits to the NoC router input, one flit per cycle, in order 0→3.
- Flow control toward the router is credit-based, one credit counter per VC.

---
 rtl/fabric_port_pkg.sv | 30 +++
 rtl/flit_serializer_if.sv | 28 ++
 rtl/credit_counter.sv | 41 ++++
 rtl/flit_serializer.sv | 121 ++++++++++++
 tb/tb_flit_serializer.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fabric_port_pkg.sv
// Shared definitions for the fabric-port blocks: flit header layout, serializer
// state encoding and packed-word flit extraction.
package fabric_port_pkg;

    // Header field positions counted down from the flit MSB; the VC field starts VC_LSB bits below it.
    localparam int unsigned VALID_BIT  = 0;
    localparam int unsigned SOP_BIT    = 1;
    localparam int unsigned EOP_BIT    = 2;
    localparam int unsigned VC_LSB     = 3;

    localparam int unsigned MAX_WORD_W = 512;

    typedef enum logic {
        IDLE,
        SEND
    } state_e;

    // Flit 0 occupies the MSBs of the packed word; callers cast to their real widths.
    function automatic logic [MAX_WORD_W-1:0] get_flit(input logic [MAX_WORD_W-1:0] word,
                                                       input int unsigned width_in,
                                                       input int unsigned idx);
        logic [MAX_WORD_W-1:0] mask;
        int unsigned           fw;
        fw   = width_in / 4;
        mask = '1;
        mask = mask >> (MAX_WORD_W - fw);
        return (word >> ((3 - idx) * fw)) & mask;
    endfunction

endpackage

// File: rtl/flit_serializer_if.sv
// Word-in / flit-out handshake bundle of the flit serializer.
interface flit_serializer_if #(
    parameter int unsigned WIDTH_IN = 36
);
    localparam int unsigned FLIT_WIDTH = WIDTH_IN / 4;

    logic [WIDTH_IN-1:0]   i_packet_in;
    logic                  i_valid_in;
    logic                  i_ready_out;
    logic [FLIT_WIDTH-1:0] o_flit_out;
    logic                  o_valid_out;

    modport slave (
        input  i_packet_in,
        input  i_valid_in,
        output i_ready_out,
        output o_flit_out,
        output o_valid_out
    );

    modport master (
        output i_packet_in,
        output i_valid_in,
        input  i_ready_out,
        input  o_flit_out,
        input  o_valid_out
    );
endinterface

// File: rtl/credit_counter.sv
// Per-VC credit counter toward the router input buffer, with sticky overflow flag.
module credit_counter #(
    parameter int unsigned BUFFER_DEPTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_consume,
    input  logic i_return,
    output logic o_has_credit,
    output logic o_ovf
);
    localparam int unsigned    CW   = $clog2(BUFFER_DEPTH + 1);
    localparam logic [CW-1:0]  FULL = CW'(BUFFER_DEPTH);

    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= FULL;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (i_consume && !i_return) begin
            count_d = count_q - CW'(1);
        end else if (i_return && !i_consume) begin
            if (count_q == FULL) ovf_d = 1'b1;
            else                 count_d = count_q + CW'(1);
        end
    end

    assign o_has_credit = (count_q != '0);
    assign o_ovf        = ovf_q;
endmodule

// File: rtl/flit_serializer.sv
// Serializes a packed 4-flit word into one flit per cycle under per-VC credit flow control.
// Optional FLIT_SERIALIZER_STATS_EN adds o_flit_count / o_pkt_count statistics outputs.
module flit_serializer
    import fabric_port_pkg::*;
#(
    parameter int unsigned WIDTH_IN         = 36,
    parameter int unsigned VC_ADDRESS_WIDTH = 1,
    parameter int unsigned BUFFER_DEPTH     = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    flit_serializer_if.slave                port,
    input  logic [2**VC_ADDRESS_WIDTH-1:0]  i_credit_in,
    output logic                            o_credit_ovf
`ifdef FLIT_SERIALIZER_STATS_EN
   ,output logic [31:0]                     o_flit_count,
    output logic [31:0]                     o_pkt_count
`endif
);
    localparam int unsigned FLIT_WIDTH = WIDTH_IN / 4;
    localparam int unsigned NUM_VC     = 2**VC_ADDRESS_WIDTH;
    localparam int unsigned VC_HI      = FLIT_WIDTH - 1 - VC_LSB;

    state_e                         state_q, state_d;
    logic [WIDTH_IN-1:0]            word_q, word_d;
    logic [3:0]                     pend_q, pend_d;

    logic [FLIT_WIDTH-1:0]          flits [4];
    logic [3:0]                     in_valid;
    logic [1:0]                     cur_idx;
    logic [FLIT_WIDTH-1:0]          cur_flit;
    logic [VC_ADDRESS_WIDTH-1:0]    cur_vc;
    logic [3:0]                     pend_left;
    logic                           xfer, ready;
    logic [NUM_VC-1:0]              consume, has_credit, ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            word_q  <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            pend_q  <= pend_d;
        end
    end

    // Lowest-numbered pending flit wins, so invalid flits cost no cycles.
    always_comb begin
        cur_idx = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            flits[i]    = FLIT_WIDTH'(get_flit(MAX_WORD_W'(word_q), WIDTH_IN, i));
            in_valid[i] = port.i_packet_in[WIDTH_IN - 1 - VALID_BIT - i * FLIT_WIDTH];
        end
        for (int unsigned i = 0; i < 4; i++) begin
            if (pend_q[3 - i]) cur_idx = 2'(3 - i);
        end
        cur_flit  = flits[cur_idx];
        cur_vc    = cur_flit[VC_HI -: VC_ADDRESS_WIDTH];
        pend_left = pend_q & ~(4'b0001 << cur_idx);
    end

    // Ready rises combinationally on the last transfer so the next word loads without a bubble.
    always_comb begin
        xfer             = (state_q == SEND) && has_credit[cur_vc];
        ready            = (state_q == IDLE) || (xfer && (pend_left == '0));
        port.o_valid_out = xfer;
        port.o_flit_out  = (state_q == SEND) ? cur_flit : '0;
        port.i_ready_out = ready;
        consume          = '0;
        if (xfer) consume[cur_vc] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        pend_d  = pend_q;
        if (xfer) begin
            pend_d = pend_left;
            if (pend_left == '0) state_d = IDLE;
        end
        if (port.i_valid_in && ready) begin
            word_d  = port.i_packet_in;
            pend_d  = in_valid;
            state_d = (in_valid != '0) ? SEND : IDLE;
        end
    end

    for (genvar v = 0; v < NUM_VC; v++) begin : g_credit
        credit_counter #(
            .BUFFER_DEPTH (BUFFER_DEPTH)
        ) u_credit (
            .clk          (clk),
            .rst_n        (rst_n),
            .i_consume    (consume[v]),
            .i_return     (i_credit_in[v]),
            .o_has_credit (has_credit[v]),
            .o_ovf        (ovf[v])
        );
    end

    assign o_credit_ovf = |ovf;

`ifdef FLIT_SERIALIZER_STATS_EN
    logic [31:0] flit_cnt_q, pkt_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flit_cnt_q <= '0;
            pkt_cnt_q  <= '0;
        end else if (xfer) begin
            flit_cnt_q <= flit_cnt_q + 32'd1;
            if (cur_flit[FLIT_WIDTH - 1 - EOP_BIT]) pkt_cnt_q <= pkt_cnt_q + 32'd1;
        end
    end

    assign o_flit_count = flit_cnt_q;
    assign o_pkt_count  = pkt_cnt_q;
`endif
endmodule

// File: tb/tb_flit_serializer.sv
// Self-checking bench for flit_serializer: vector table plus scoreboard of expected flits.
module tb_flit_serializer;
    import fabric_port_pkg::*;

    localparam int unsigned WIDTH_IN = 36;
    localparam int unsigned FW       = 9;
    localparam int unsigned VCW      = 1;
    localparam int unsigned DEPTH    = 8;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b1;
    logic [1:0] i_credit_in;
    logic       o_credit_ovf;
    logic       auto_ret = 1'b0;
    logic [1:0] man_ret  = 2'b00;
`ifdef FLIT_SERIALIZER_STATS_EN
    logic [31:0] o_flit_count, o_pkt_count;
`endif

    always #5 clk = ~clk;

    flit_serializer_if #(.WIDTH_IN(WIDTH_IN)) fif ();

    // Router model: in auto mode each transferred flit returns its credit in the same cycle.
    assign i_credit_in = auto_ret ? (fif.o_valid_out ? (2'b01 << fif.o_flit_out[FW - 1 - VC_LSB]) : 2'b00)
                                  : man_ret;

    flit_serializer #(
        .WIDTH_IN         (WIDTH_IN),
        .VC_ADDRESS_WIDTH (VCW),
        .BUFFER_DEPTH     (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .port         (fif),
        .i_credit_in  (i_credit_in),
        .o_credit_ovf (o_credit_ovf)
`ifdef FLIT_SERIALIZER_STATS_EN
       ,.o_flit_count (o_flit_count),
        .o_pkt_count  (o_pkt_count)
`endif
    );

    typedef struct {
        logic [FW-1:0] flit;
        logic          last;
    } exp_t;

    typedef struct {
        logic [WIDTH_IN-1:0] word;
        int                  n;
    } vec_t;

    exp_t exp_q[$];
    int   times[$];
    int   cyc     = 0;
    int   acc_cyc = 0;
    int   checks  = 0;
    int   errors  = 0;
    vec_t tbl[7];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [FW-1:0] mkf(input logic v, input logic s, input logic e,
                                          input logic vc, input int p);
        logic [FW-1:0] f;
        f = '0;
        f[FW - 1 - VALID_BIT] = v;
        f[FW - 1 - SOP_BIT]   = s;
        f[FW - 1 - EOP_BIT]   = e;
        f[FW - 1 - VC_LSB]    = vc;
        f[4:0]                = 5'(p);
        return f;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push_expected(input logic [WIDTH_IN-1:0] w);
        int            last_i;
        logic [FW-1:0] f;
        last_i = -1;
        for (int i = 0; i < 4; i++) begin
            f = w[WIDTH_IN - 1 - i * FW -: FW];
            if (f[FW - 1]) last_i = i;
        end
        for (int i = 0; i < 4; i++) begin
            f = w[WIDTH_IN - 1 - i * FW -: FW];
            if (f[FW - 1]) exp_q.push_back('{flit: f, last: (i == last_i)});
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [WIDTH_IN-1:0] w);
        bit ok;
        ok = 1'b0;
        fif.i_packet_in = w;
        fif.i_valid_in  = 1'b1;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (fif.i_ready_out) begin
                push_expected(w);
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
            acc_cyc = cyc;
        end
        fif.i_valid_in = 1'b0;
        if (!ok) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        fif.i_valid_in = 1'b0;
        man_ret        = 2'b00;
        exp_q.delete();
        times.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [WIDTH_IN-1:0] w_full, w_b2b;
        logic [FW-1:0]       held;
        int                  p_cyc;

        fif.i_packet_in = '0;
        fif.i_valid_in  = 1'b0;

        // Scoreboard monitor: a flit shown at a negedge transfers at the following posedge.
        fork
            forever begin
                exp_t e;
                @(negedge clk);
                if (rst_n && fif.o_valid_out) begin
                    times.push_back(cyc + 1);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_flit", {55'd0, fif.o_flit_out}, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("flit_out", {55'd0, fif.o_flit_out}, {55'd0, e.flit});
                        chk("ready_with_flit", {63'd0, fif.i_ready_out}, {63'd0, e.last});
                    end
                end
            end
        join_none

        w_full = {mkf(1,1,0,0,1), mkf(1,0,0,0,2), mkf(1,0,0,0,3), mkf(1,0,1,0,4)};
        w_b2b  = {mkf(1,1,0,0,20), mkf(1,0,0,0,21), mkf(1,0,0,0,22), mkf(1,0,1,0,23)};

        tbl[0] = '{w_full, 4};
        tbl[1] = '{{mkf(1,1,0,0,5), mkf(0,0,0,0,6), mkf(1,0,1,0,7), mkf(0,0,0,0,8)}, 2};
        tbl[2] = '{{mkf(0,1,0,1,9), mkf(0,0,0,0,10), mkf(0,0,0,1,11), mkf(0,0,1,0,12)}, 0};
        tbl[3] = '{{mkf(0,1,1,1,3), mkf(1,1,0,1,13), mkf(0,0,0,0,2), mkf(1,0,1,1,14)}, 2};
        tbl[4] = '{{mkf(0,0,0,0,0), mkf(0,0,0,0,0), mkf(0,1,0,0,7), mkf(1,1,1,0,15)}, 1};
        tbl[5] = '{{mkf(1,1,0,1,16), mkf(1,0,0,0,17), mkf(1,0,0,1,18), mkf(1,0,1,0,19)}, 4};
        tbl[6] = '{{mkf(0,0,0,0,1), mkf(1,1,0,1,24), mkf(1,0,1,0,25), mkf(0,0,0,0,2)}, 2};

        #1 rst_n = 1'b0;
        #11;
        chk("reset_ready", {63'd0, fif.i_ready_out}, 64'd1);
        chk("reset_valid", {63'd0, fif.o_valid_out}, 64'd0);
        chk("reset_flit",  {55'd0, fif.o_flit_out},  64'd0);
        chk("reset_ovf",   {63'd0, o_credit_ovf},    64'd0);
        do_reset();

        auto_ret = 1'b1;
        foreach (tbl[i]) begin
            times.delete();
            send_word(tbl[i].word);
            wait_cycles(tbl[i].n + 3);
            chk("vec_flit_count", 64'(times.size()), 64'(tbl[i].n));
            for (int k = 0; k < tbl[i].n && k < times.size(); k++)
                chk("vec_flit_cycle", 64'(times[k]), 64'(acc_cyc + 1 + k));
            chk("vec_drained", 64'(exp_q.size()), 64'd0);
            chk("vec_idle_ready", {63'd0, fif.i_ready_out}, 64'd1);
        end

        // Back-to-back words: eight flits on eight consecutive cycles.
        do_reset();
        times.delete();
        send_word(w_full);
        send_word(w_b2b);
        wait_cycles(8);
        chk("b2b_count", 64'(times.size()), 64'd8);
        for (int k = 1; k < 8 && k < times.size(); k++)
            chk("b2b_no_bubble", 64'(times[k]), 64'(times[0] + k));

        // Credit exhaustion on VC0, then one returned credit releases exactly one flit.
        auto_ret = 1'b0;
        do_reset();
        send_word(w_full);
        send_word(w_full);
        send_word(w_b2b);
        wait_cycles(6);
        chk("exhaust_count", 64'(times.size()), 64'd8);
        chk("exhaust_valid", {63'd0, fif.o_valid_out}, 64'd0);
        held = mkf(1,1,0,0,20);
        chk("stall_flit", {55'd0, fif.o_flit_out}, {55'd0, held});
        wait_cycles(2);
        chk("stall_flit_stable", {55'd0, fif.o_flit_out}, {55'd0, held});
        man_ret = 2'b01;
        @(posedge clk);
        #1;
        p_cyc   = cyc;
        man_ret = 2'b00;
        wait_cycles(4);
        chk("one_credit_count", 64'(times.size()), 64'd9);
        if (times.size() > 8) chk("one_credit_cycle", 64'(times[8]), 64'(p_cyc + 1));
        chk("restall_valid", {63'd0, fif.o_valid_out}, 64'd0);

        // Consume and return on VC0 in the same cycle at count 3: nine flits fit in total.
        do_reset();
        fork
            begin
                send_word(w_full);
                send_word(w_full);
                send_word(w_full);
            end
            begin
                for (int k = 0; k < 100; k++) begin
                    @(negedge clk);
                    #1;
                    if (times.size() == 6) begin
                        man_ret = 2'b01;
                        @(posedge clk);
                        #1;
                        man_ret = 2'b00;
                        break;
                    end
                end
            end
        join
        wait_cycles(8);
        chk("simul_count", 64'(times.size()), 64'd9);
        chk("simul_no_ovf", {63'd0, o_credit_ovf}, 64'd0);

        // Return while full: counter holds at 8 and the sticky flag rises.
        do_reset();
        man_ret = 2'b01;
        @(posedge clk);
        #1;
        man_ret = 2'b00;
        chk("ovf_set", {63'd0, o_credit_ovf}, 64'd1);
        wait_cycles(5);
        chk("ovf_sticky", {63'd0, o_credit_ovf}, 64'd1);
        send_word(w_full);
        send_word(w_full);
        send_word(w_full);
        wait_cycles(8);
        chk("ovf_count_held", 64'(times.size()), 64'd8);
        chk("ovf_still_set", {63'd0, o_credit_ovf}, 64'd1);

        // Reset mid-word after two flits: outputs clear at once and credits restore.
        do_reset();
        send_word(w_full);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", {63'd0, fif.i_ready_out}, 64'd1);
        chk("midrst_valid", {63'd0, fif.o_valid_out}, 64'd0);
        chk("midrst_flit",  {55'd0, fif.o_flit_out},  64'd0);
        chk("midrst_ovf",   {63'd0, o_credit_ovf},    64'd0);
        do_reset();
        send_word(w_full);
        send_word(w_full);
        send_word(w_full);
        wait_cycles(8);
        chk("midrst_credits", 64'(times.size()), 64'd8);

`ifdef FLIT_SERIALIZER_STATS_EN
        auto_ret = 1'b1;
        do_reset();
        send_word(w_full);
        send_word({mkf(1,1,0,1,5), mkf(1,0,0,1,6), mkf(1,0,1,1,7), mkf(1,1,0,0,8)});
        send_word({mkf(1,0,0,0,9), mkf(1,0,1,0,10), mkf(0,0,0,0,0), mkf(0,0,0,0,0)});
        wait_cycles(8);
        chk("stats_flits", {32'd0, o_flit_count}, 64'd10);
        chk("stats_pkts",  {32'd0, o_pkt_count},  64'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
